// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// The CLKDIV_SYNC_EN build option (in clk_div_multi) adds a phase-align input.
package clk_div_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned CTR_W_DEF = 32;

  function automatic int unsigned half_period(input int unsigned hz);
    return CLK_HZ / (2 * hz);
  endfunction

  localparam int unsigned DIV_DEFAULT = half_period(1);

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, pending half-period and registered outputs.
// A pending value takes effect at a toggle edge, or at once when stalled.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      CTR_W   = CTR_W_DEF,
  parameter logic [CTR_W-1:0] DIV_RST = CTR_W'(DIV_DEFAULT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [CTR_W-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o
);

  localparam logic [CTR_W-1:0] ONE = CTR_W'(1);

  logic [CTR_W-1:0] div_q;
  logic [CTR_W-1:0] pend_q;
  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] next_div;
  logic             clk_q;
  logic             tick_q;
  logic             busy_q;
  logic             run;
  logic             term;
  logic             sync_hit;

  assign run      = en_i && (div_q != '0);
  assign term     = run && (ctr_q == div_q - ONE);
  assign sync_hit = sync_i && run;
  // A load arriving on a boundary cycle wins over the older pending value
  assign next_div = load_i ? div_i : pend_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctr_q  <= '0;
      div_q  <= DIV_RST;
      pend_q <= '0;
      busy_q <= 1'b0;
      clk_q  <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (load_i) begin
        pend_q <= div_i;
        busy_q <= 1'b1;
      end
      if (sync_hit) begin
        ctr_q  <= '0;
        clk_q  <= 1'b1;
        tick_q <= !clk_q;
        if (busy_q || load_i) begin
          div_q  <= next_div;
          busy_q <= 1'b0;
        end
      end else if (term) begin
        ctr_q  <= '0;
        clk_q  <= !clk_q;
        tick_q <= 1'b1;
        if (busy_q || load_i) begin
          div_q  <= next_div;
          busy_q <= 1'b0;
        end
      end else if (run) begin
        ctr_q <= ctr_q + ONE;
      end else if (busy_q) begin
        // Stalled channel: apply now, keep any same-cycle load pending
        div_q  <= pend_q;
        ctr_q  <= '0;
        busy_q <= load_i;
      end
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/clk_div_multi.sv
// CH independent programmable clock dividers with tick strobes.
// Define CLKDIV_SYNC_EN to add sync_i, which phase-aligns all channels.
module clk_div_multi #(
  parameter int unsigned      CH          = 2,
  parameter int unsigned      CTR_W       = clk_div_pkg::CTR_W_DEF,
  parameter logic [CTR_W-1:0] DIV_DEFAULT = CTR_W'(clk_div_pkg::DIV_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic [CH-1:0]       en_i,
  input  logic [CH*CTR_W-1:0] div_i,
  input  logic [CH-1:0]       load_i,
  output logic [CH-1:0]       clk_o,
  output logic [CH-1:0]       tick_o,
  output logic [CH-1:0]       busy_o
);

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  for (genvar k = 0; k < CH; k++) begin : g_ch
    clk_div_chan #(
      .CTR_W   (CTR_W),
      .DIV_RST (DIV_DEFAULT)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i[k]),
      .sync_i (sync),
      .load_i (load_i[k]),
      .div_i  (div_i[k*CTR_W +: CTR_W]),
      .clk_o  (clk_o[k]),
      .tick_o (tick_o[k]),
      .busy_o (busy_o[k])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: vector table, corner sequences, random vs model.
// Sync checks are compiled in when CLKDIV_SYNC_EN is defined.
module tb_clk_div_multi;

  localparam int CH = 2;
  localparam int W  = 8;
  localparam int DD = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sync_v = 1'b0;
  logic [CH-1:0]     en = '0;
  logic [CH-1:0]     load = '0;
  logic [CH*W-1:0]   div_v = '0;
  logic [CH-1:0]     clk_o, tick_o, busy_o;

  int nvec = 0;
  int nerr = 0;

  // Model: level, half-period, cycles left in phase, pending value
  bit m_lvl[CH];
  bit m_tick[CH];
  bit m_pv[CH];
  int m_div[CH];
  int m_left[CH];
  int m_pval[CH];

  always #5 clk = ~clk;

  clk_div_multi #(
    .CH          (CH),
    .CTR_W       (W),
    .DIV_DEFAULT (W'(DD))
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
`ifdef CLKDIV_SYNC_EN
    .sync_i (sync_v),
`endif
    .en_i   (en),
    .div_i  (div_v),
    .load_i (load),
    .clk_o  (clk_o),
    .tick_o (tick_o),
    .busy_o (busy_o)
  );

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic [1:0] ld;
    logic [7:0] d0;
    logic [1:0] c;
    logic [1:0] t;
    logic [1:0] b;
  } vec_t;

  vec_t tbl[15];

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, got, want);
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < CH; k++) begin
      int dv;
      int nd;
      dv = int'(div_v[k*W +: W]);
      m_tick[k] = 1'b0;
      if (rst) begin
        m_lvl[k]  = 1'b1;
        m_div[k]  = DD;
        m_left[k] = DD;
        m_pv[k]   = 1'b0;
      end else if (sync_v && en[k] && m_div[k] > 0) begin
        m_tick[k] = !m_lvl[k];
        m_lvl[k]  = 1'b1;
        nd = load[k] ? dv : (m_pv[k] ? m_pval[k] : m_div[k]);
        m_div[k]  = nd;
        m_left[k] = nd;
        m_pv[k]   = 1'b0;
        if (load[k]) m_pval[k] = dv;
      end else if (en[k] && m_div[k] > 0) begin
        if (m_left[k] == 1) begin
          m_lvl[k]  = !m_lvl[k];
          m_tick[k] = 1'b1;
          nd = load[k] ? dv : (m_pv[k] ? m_pval[k] : m_div[k]);
          m_div[k]  = nd;
          m_left[k] = nd;
          m_pv[k]   = 1'b0;
          if (load[k]) m_pval[k] = dv;
        end else begin
          m_left[k]--;
          if (load[k]) begin
            m_pv[k]   = 1'b1;
            m_pval[k] = dv;
          end
        end
      end else begin
        if (m_pv[k]) begin
          m_div[k]  = m_pval[k];
          m_left[k] = m_pval[k];
        end
        m_pv[k] = load[k];
        if (load[k]) m_pval[k] = dv;
      end
    end
  endfunction

  function automatic logic [3*CH-1:0] m_out();
    logic [CH-1:0] c, t, b;
    for (int k = 0; k < CH; k++) begin
      c[k] = m_lvl[k];
      t[k] = m_tick[k];
      b[k] = m_pv[k];
    end
    return {c, t, b};
  endfunction

  task automatic setdiv(input int k, input int v);
    div_v[k*W +: W] = W'(v);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("model", 32'({clk_o, tick_o, busy_o}), 32'(m_out()));
    load   = '0;
    rst    = 1'b0;
    sync_v = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    bit [8:0] got9;

    //           rst en     ld     d0  clk    tick   busy
    tbl[0]  = '{1, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00};
    tbl[1]  = '{0, 2'b11, 2'b00, 0, 2'b11, 2'b00, 2'b00};
    tbl[2]  = '{0, 2'b11, 2'b00, 0, 2'b11, 2'b00, 2'b00};
    tbl[3]  = '{0, 2'b11, 2'b00, 0, 2'b00, 2'b11, 2'b00};
    tbl[4]  = '{0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{0, 2'b11, 2'b00, 0, 2'b11, 2'b11, 2'b00};
    tbl[7]  = '{0, 2'b11, 2'b01, 1, 2'b11, 2'b00, 2'b01};
    tbl[8]  = '{0, 2'b11, 2'b00, 1, 2'b11, 2'b00, 2'b01};
    tbl[9]  = '{0, 2'b11, 2'b00, 1, 2'b00, 2'b11, 2'b00};
    tbl[10] = '{0, 2'b11, 2'b00, 1, 2'b01, 2'b01, 2'b00};
    tbl[11] = '{0, 2'b11, 2'b00, 1, 2'b00, 2'b01, 2'b00};
    tbl[12] = '{0, 2'b11, 2'b00, 1, 2'b11, 2'b11, 2'b00};
    tbl[13] = '{0, 2'b01, 2'b00, 1, 2'b10, 2'b01, 2'b00};
    tbl[14] = '{1, 2'b11, 2'b00, 1, 2'b11, 2'b00, 2'b00};

    for (int i = 0; i < 15; i++) begin
      rst  = tbl[i].rst;
      en   = tbl[i].en;
      load = tbl[i].ld;
      setdiv(0, int'(tbl[i].d0));
      cycle();
      chk($sformatf("tbl%0d", i), 32'({clk_o, tick_o, busy_o}),
          32'({tbl[i].c, tbl[i].t, tbl[i].b}));
    end

    // Idle channel picks up div 1 one cycle after the load is seen
    load[0] = 1'b1;
    setdiv(0, 0);
    cycle();
    for (n = 0; n < 20 && (busy_o[0] || m_div[0] != 0); n++) cycle();
    chk("idle_reach", 32'(n < 20), 1);
    load[0] = 1'b1;
    setdiv(0, 1);
    cycle();
    chk("busy_rise", 32'(busy_o[0]), 1);
    cycle();
    chk("idle_apply", 32'({busy_o[0], tick_o[0]}), 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("tick_cont", 32'(tick_o[0]), 1);
    end

    // Div 4 running, load 2 in cycle 1 of a high phase
    load[0] = 1'b1;
    setdiv(0, 4);
    cycle();
    for (n = 0; n < 20 && !(tick_o[0] && clk_o[0]); n++) cycle();
    chk("rise4", 32'(n < 20), 1);
    got9 = '0;
    got9[0] = clk_o[0];
    for (int i = 1; i < 9; i++) begin
      if (i == 2) begin
        load[0] = 1'b1;
        setdiv(0, 2);
      end
      cycle();
      got9[i] = clk_o[0];
      if (i == 2 || i == 3) chk("busy_hold", 32'(busy_o[0]), 1);
      if (i == 4) chk("busy_clr", 32'(busy_o[0]), 0);
    end
    chk("seq_4_2", 32'(got9), 32'(9'b011001111));

    // Div 5, enable dropped for 7 cycles at count 2
    load[0] = 1'b1;
    setdiv(0, 5);
    cycle();
    for (n = 0; n < 20 && busy_o[0]; n++) cycle();
    for (n = 0; n < 20 && !(tick_o[0] && clk_o[0]); n++) cycle();
    chk("rise5", 32'(n < 20), 1);
    cycle();
    cycle();
    en[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("frozen", 32'({clk_o[0], tick_o[0]}), 32'(2'b10));
    end
    en[0] = 1'b1;
    cycle();
    cycle();
    chk("resume_hold", 32'(clk_o[0]), 1);
    cycle();
    chk("resume_edge", 32'({clk_o[0], tick_o[0]}), 32'(2'b01));

    // Reset in the middle of a low phase with a load pending
    cycle();
    load[0] = 1'b1;
    setdiv(0, 6);
    cycle();
    chk("pre_rst", 32'({clk_o[0], busy_o[0]}), 32'(2'b01));
    rst = 1'b1;
    cycle();
    chk("rst_mid", 32'({clk_o, tick_o, busy_o}), 32'(6'b110000));
    got9 = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      got9[i] = clk_o[0];
    end
    chk("rst_phase", 32'(got9), 32'(9'b000000011));

    // Largest legal half-period on channel 1
    load[1] = 1'b1;
    setdiv(1, 255);
    cycle();
    for (n = 0; n < 20 && busy_o[1]; n++) cycle();
    for (n = 0; n < 600 && !(tick_o[1] && clk_o[1]); n++) cycle();
    chk("rise255", 32'(n < 600), 1);
    hi = 1;
    for (n = 0; n < 600 && clk_o[1]; n++) begin
      cycle();
      if (clk_o[1]) hi++;
    end
    chk("high255", 32'(hi), 255);
    hi = 1;
    for (n = 0; n < 600 && !clk_o[1]; n++) begin
      cycle();
      if (!clk_o[1]) hi++;
    end
    chk("low255", 32'(hi), 255);

`ifdef CLKDIV_SYNC_EN
    begin
      int f0, f1;
      rst = 1'b1;
      cycle();
      load[1] = 1'b1;
      setdiv(1, 7);
      cycle();
      for (n = 0; n < 20 && busy_o[1]; n++) cycle();
      for (int i = 0; i < 5; i++) cycle();
      sync_v = 1'b1;
      cycle();
      chk("sync_hi", 32'(clk_o), 32'(2'b11));
      f0 = 0;
      f1 = 0;
      for (int i = 1; i <= 8; i++) begin
        cycle();
        if (f0 == 0 && !clk_o[0]) f0 = i;
        if (f1 == 0 && !clk_o[1]) f1 = i;
      end
      chk("sync_fall0", 32'(f0), 3);
      chk("sync_fall1", 32'(f1), 7);
    end
`endif

    // Random traffic against the model
    rst = 1'b1;
    cycle();
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < CH; k++) begin
        en[k] = ($urandom_range(9) != 0);
        if ($urandom_range(9) == 0) begin
          load[k] = 1'b1;
          setdiv(k, int'($urandom_range(6)));
        end
      end
      rst = ($urandom_range(299) == 0);
`ifdef CLKDIV_SYNC_EN
      sync_v = ($urandom_range(99) == 0);
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
